pipe_ctrl: RTL and testbench

//  Parametrised pipeline control unit, successor to the single-source jump/hold ctrl of the core.
//  - Arbitrates NUM_JSRC jump requests.
//  - Merges per-stage stall requests and multi-cycle holds (mul/div, bus wait).
//  - Drives per-stage stall/flush vectors for the pipeline registers (if_id, id_ex, ...) and the jump to pc_reg.
//  - Defers a jump that collides with an older-stage stall or hold until the pipeline can take it.

---
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: jump arbitration, stall/hold merge and deferred-jump sequencing for the pipeline registers.
// Optional feature macro PIPE_CTRL_PERF_EN adds saturating stall-cycle and jump-event counters.
module pipe_ctrl #(
  parameter int STAGES     = 4,
  parameter int NUM_JSRC   = 2,
  parameter int ADDR_W     = 32,
  parameter int JUMP_STAGE = 2,
  parameter int HOLD_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_JSRC-1:0]        jump_en_i,
  input  logic [NUM_JSRC*ADDR_W-1:0] jump_addr_i,
  input  logic [STAGES-1:0]          stall_req_i,
  input  logic                       hold_req_i,
  input  logic [HOLD_W-1:0]          hold_cycles_i,
  output logic                       jump_en_o,
  output logic [ADDR_W-1:0]          jump_addr_o,
  output logic [STAGES-1:0]          stall_o,
  output logic [STAGES-1:0]          flush_o,
  output logic                       busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                stall_cyc_o,
  output logic [31:0]                flush_evt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_nxt;
  logic                pend_valid, pend_valid_nxt;

  logic [STAGES-1:0]   merge_stall;
  logic [STAGES-1:0]   merge_flush;
  logic [STAGES-1:0]   jump_mask;
  logic                older_stall;
  logic                win_vld;
  logic [ADDR_W-1:0]   win_addr;
  logic [HOLD_W-1:0]   hold_len_m1;

  // A stage stalls when it or any older stage stalls; the first free stage above gets a bubble.
  always_comb begin
    merge_stall = '0;
    merge_flush = '0;
    jump_mask   = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (j == STAGES - 1) merge_stall[j] = stall_req_i[j];
      else                 merge_stall[j] = stall_req_i[j] | merge_stall[j+1];
    end
    for (int j = 1; j < STAGES; j++) begin
      merge_flush[j] = merge_stall[j-1] & ~merge_stall[j];
    end
    for (int j = 0; j < STAGES; j++) begin
      jump_mask[j] = (j < JUMP_STAGE);
    end
  end

  assign older_stall = |(stall_req_i & ~jump_mask);

  // Lowest-index source wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_vld  = 1'b0;
    win_addr = '0;
    for (int s = NUM_JSRC - 1; s >= 0; s--) begin
      if (jump_en_i[s]) begin
        win_vld  = 1'b1;
        win_addr = jump_addr_i[s*ADDR_W +: ADDR_W];
      end
    end
  end

  assign hold_len_m1 = (hold_cycles_i == '0) ? '0 : hold_cycles_i - HOLD_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    pend_addr_nxt  = pend_addr;
    pend_valid_nxt = pend_valid;
    jump_en_o      = 1'b0;
    jump_addr_o    = '0;
    stall_o        = merge_stall;
    flush_o        = merge_flush;

    unique case (state)
      IDLE: begin
        if (hold_req_i) begin
          stall_o      = '1;
          flush_o      = '0;
          hold_cnt_nxt = hold_len_m1;
          if (win_vld) begin
            pend_addr_nxt  = win_addr;
            pend_valid_nxt = 1'b1;
          end
          if (hold_len_m1 != '0) state_nxt = HOLD;
          else if (win_vld)      state_nxt = PEND;
        end else if (win_vld) begin
          if (older_stall) begin
            pend_addr_nxt  = win_addr;
            pend_valid_nxt = 1'b1;
            state_nxt      = PEND;
          end else begin
            jump_en_o   = 1'b1;
            jump_addr_o = win_addr;
            flush_o     = merge_flush | jump_mask;
            stall_o     = merge_stall & ~jump_mask;
          end
        end
      end

      HOLD: begin
        stall_o      = '1;
        flush_o      = '0;
        hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        // Only the first jump seen during a hold is kept; later ones are younger and get flushed.
        if (win_vld && !pend_valid) begin
          pend_addr_nxt  = win_addr;
          pend_valid_nxt = 1'b1;
        end
        if (hold_cnt == HOLD_W'(1)) begin
          state_nxt = (pend_valid || win_vld) ? PEND : IDLE;
        end
      end

      PEND: begin
        if (!older_stall) begin
          jump_en_o      = 1'b1;
          jump_addr_o    = pend_addr;
          flush_o        = merge_flush | jump_mask;
          stall_o        = merge_stall & ~jump_mask;
          pend_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt      = IDLE;
        pend_valid_nxt = 1'b0;
      end
    endcase
  end

  assign busy_o = (state != IDLE);

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_o <= '0;
      flush_evt_o <= '0;
    end else begin
      if (|stall_o) stall_cyc_o <= sat_inc(stall_cyc_o);
      if (jump_en_o) flush_evt_o <= sat_inc(flush_evt_o);
    end
  end
`endif

  a_addr_zero: assert property (@(posedge clk) disable iff (!rst) !jump_en_o |-> (jump_addr_o == '0));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, hand-written multi-cycle sequences and randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  localparam int STAGES     = 4;
  localparam int NUM_JSRC   = 2;
  localparam int ADDR_W     = 32;
  localparam int JUMP_STAGE = 2;
  localparam int HOLD_W     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  jump_en = '0;
  logic [63:0] jump_addr = '0;
  logic [3:0]  stall_req = '0;
  logic        hold_req = 1'b0;
  logic [3:0]  hold_cycles = '0;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [3:0]  stall_o;
  logic [3:0]  flush_o;
  logic        busy_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc;
  logic [31:0] flush_evt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(
    .STAGES(STAGES), .NUM_JSRC(NUM_JSRC), .ADDR_W(ADDR_W),
    .JUMP_STAGE(JUMP_STAGE), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .stall_req_i(stall_req), .hold_req_i(hold_req), .hold_cycles_i(hold_cycles),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_o(stall_o), .flush_o(flush_o), .busy_o(busy_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cyc_o(stall_cyc), .flush_evt_o(flush_evt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Packed as {jump_en, addr, stall, flush, busy}.
  task automatic expect_out(input string name, input logic je, input logic [31:0] a,
                            input logic [3:0] st, input logic [3:0] fl, input logic b);
    check(name, {22'd0, jump_en_o, jump_addr_o, stall_o, flush_o, busy_o},
                {22'd0, je, a, st, fl, b});
  endtask

  task automatic apply(input logic [1:0] je, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] sr, input logic hr, input logic [3:0] hc);
    @(negedge clk);
    jump_en     = je;
    jump_addr   = {a1, a0};
    stall_req   = sr;
    hold_req    = hr;
    hold_cycles = hc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 4'h0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  je;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  sr;
    logic        eje;
    logic [31:0] ea;
    logic [3:0]  est;
    logic [3:0]  efl;
  } vec_t;

  vec_t vecs[9];

  // Reference model state: remaining hold cycles and at most one deferred jump.
  int          hold_left;
  logic [31:0] pendq[$];
  int          m_stall_cnt;
  int          m_jump_cnt;

  task automatic model_step(output logic eje, output logic [31:0] ea, output logic [3:0] est,
                            output logic [3:0] efl, output logic eb);
    int          k_top;
    logic [3:0]  mst, mfl, jm;
    logic        older, win;
    logic [31:0] waddr;
    k_top = -1;
    for (int k = 0; k < STAGES; k++) if (stall_req[k]) k_top = k;
    mst   = (k_top >= 0) ? 4'((1 << (k_top + 1)) - 1) : 4'h0;
    mfl   = (k_top >= 0 && k_top + 1 < STAGES) ? 4'(1 << (k_top + 1)) : 4'h0;
    jm    = 4'((1 << JUMP_STAGE) - 1);
    older = (stall_req >> JUMP_STAGE) != 0;
    win   = (jump_en != 0);
    waddr = jump_en[0] ? jump_addr[31:0] : jump_addr[63:32];
    eje = 1'b0; ea = '0; est = mst; efl = mfl;
    eb  = (hold_left > 0) || (pendq.size() > 0);
    if (hold_left > 0) begin
      est = 4'hF; efl = 4'h0;
      if (win && pendq.size() == 0) pendq.push_back(waddr);
      hold_left--;
    end else if (pendq.size() > 0) begin
      if (!older) begin
        eje = 1'b1; ea = pendq.pop_front(); est = mst & ~jm; efl = mfl | jm;
      end
    end else if (hold_req) begin
      est = 4'hF; efl = 4'h0;
      hold_left = ((hold_cycles == 0) ? 1 : int'(hold_cycles)) - 1;
      if (win) pendq.push_back(waddr);
    end else if (win) begin
      if (older) pendq.push_back(waddr);
      else begin
        eje = 1'b1; ea = waddr; est = mst & ~jm; efl = mfl | jm;
      end
    end
  endtask

  initial begin
    logic        eje, eb;
    logic [31:0] ea;
    logic [3:0]  est, efl;

    vecs[0] = '{"jump_src1",        2'b10, 32'h0,   32'h100, 4'b0000, 1'b1, 32'h100, 4'b0000, 4'b0011};
    vecs[1] = '{"jump_prio",        2'b11, 32'h200, 32'h300, 4'b0000, 1'b1, 32'h200, 4'b0000, 4'b0011};
    vecs[2] = '{"stall0",           2'b00, 32'h0,   32'h0,   4'b0001, 1'b0, 32'h0,   4'b0001, 4'b0010};
    vecs[3] = '{"stall3",           2'b00, 32'h0,   32'h0,   4'b1000, 1'b0, 32'h0,   4'b1111, 4'b0000};
    vecs[4] = '{"jump_blocked",     2'b01, 32'h500, 32'h0,   4'b0100, 1'b0, 32'h0,   4'b0111, 4'b1000};
    vecs[5] = '{"jump_over_stall1", 2'b01, 32'h600, 32'h0,   4'b0010, 1'b1, 32'h600, 4'b0000, 4'b0111};
    vecs[6] = '{"jump_over_stall0", 2'b10, 32'h0,   32'h700, 4'b0001, 1'b1, 32'h700, 4'b0000, 4'b0011};
    vecs[7] = '{"quiet",            2'b00, 32'h0,   32'h0,   4'b0000, 1'b0, 32'h0,   4'b0000, 4'b0000};
    vecs[8] = '{"stall_mix",        2'b00, 32'h0,   32'h0,   4'b0101, 1'b0, 32'h0,   4'b0111, 4'b1000};

    // Reset behaviour
    #12;
    expect_out("in_reset", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    expect_out("after_reset", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Single-cycle vectors from IDLE
    foreach (vecs[i]) begin
      apply(vecs[i].je, vecs[i].a0, vecs[i].a1, vecs[i].sr, 1'b0, 4'h0);
      expect_out(vecs[i].name, vecs[i].eje, vecs[i].ea, vecs[i].est, vecs[i].efl, 1'b0);
      idle(2);
    end
    apply(2'b10, 32'h0, 32'h100, 4'h0, 1'b0, 4'h0);
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    expect_out("jump_one_cycle", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Hold of three cycles
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 4'd3);
    expect_out("hold3_c1", 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 4'd7);
    expect_out("hold3_c2", 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
    idle(1);
    expect_out("hold3_c3", 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
    idle(1);
    expect_out("hold3_end", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Hold with a jump arriving mid-hold
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 4'd3);
    expect_out("hj_c1", 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
    apply(2'b01, 32'h400, 32'h0, 4'h0, 1'b0, 4'h0);
    expect_out("hj_c2", 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
    apply(2'b01, 32'h444, 32'h0, 4'h0, 1'b0, 4'h0);
    expect_out("hj_c3", 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
    idle(1);
    expect_out("hj_c4", 1'b1, 32'h400, 4'h0, 4'b0011, 1'b1);
    idle(1);
    expect_out("hj_c5", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Blocked jump waits in PEND until the older stall drops
    apply(2'b01, 32'h500, 32'h0, 4'b0100, 1'b0, 4'h0);
    expect_out("pend_c1", 1'b0, 32'h0, 4'b0111, 4'b1000, 1'b0);
    apply(2'b00, 32'h0, 32'h0, 4'b0100, 1'b0, 4'h0);
    expect_out("pend_c2", 1'b0, 32'h0, 4'b0111, 4'b1000, 1'b1);
    apply(2'b00, 32'h0, 32'h0, 4'b0000, 1'b0, 4'h0);
    expect_out("pend_issue", 1'b1, 32'h500, 4'h0, 4'b0011, 1'b1);
    idle(1);
    expect_out("pend_done", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Zero hold length behaves as one cycle
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 4'd0);
    expect_out("hold0_c1", 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
    idle(1);
    expect_out("hold0_c2", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Hold of one with simultaneous jump goes straight to PEND
    apply(2'b01, 32'h800, 32'h0, 4'h0, 1'b1, 4'd1);
    expect_out("h1j_c1", 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
    idle(1);
    expect_out("h1j_c2", 1'b1, 32'h800, 4'h0, 4'b0011, 1'b1);
    idle(1);
    expect_out("h1j_c3", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Jumps and holds seen in PEND are dropped
    apply(2'b01, 32'h900, 32'h0, 4'b1000, 1'b0, 4'h0);
    apply(2'b01, 32'hA00, 32'h0, 4'b0000, 1'b1, 4'd3);
    expect_out("pend_ign_issue", 1'b1, 32'h900, 4'h0, 4'b0011, 1'b1);
    idle(1);
    expect_out("pend_ign_after", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Asynchronous reset in the middle of a hold
    apply(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 4'd5);
    idle(1);
    expect_out("rst_hold_busy", 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
    #1; rst = 1'b0; #1;
    expect_out("rst_hold_now", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    idle(1);
    expect_out("rst_hold_after", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Reset drops a pending jump
    apply(2'b01, 32'hB00, 32'h0, 4'b1000, 1'b0, 4'h0);
    idle(1);
    #1; rst = 1'b0; #1;
    @(negedge clk); rst = 1'b1;
    idle(1);
    expect_out("rst_pend_drop", 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);

    // Randomized run against the model, from a fresh reset
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    hold_left   = 0;
    pendq.delete();
    m_stall_cnt = 0;
    m_jump_cnt  = 0;
    for (int c = 0; c < 2000; c++) begin
      apply(($urandom % 4 == 0) ? 2'($urandom) : 2'b00, $urandom, $urandom,
            ($urandom % 3 == 0) ? 4'($urandom) : 4'h0, ($urandom % 8 == 0), 4'($urandom % 5));
`ifdef PIPE_CTRL_PERF_EN
      check("perf_stall_cyc", 64'(stall_cyc), 64'(m_stall_cnt));
      check("perf_flush_evt", 64'(flush_evt), 64'(m_jump_cnt));
`endif
      model_step(eje, ea, est, efl, eb);
      expect_out("random", eje, ea, est, efl, eb);
      if (est != 0) m_stall_cnt++;
      if (eje) m_jump_cnt++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
